// File: rtl/flags_pkg.sv
// Shared definitions for the ALU flag register and its branch checkpoints.
package flags_pkg;

    localparam int unsigned ALU_FLAGS_WIDTH = 5;
    localparam int unsigned NZCV_WIDTH      = 4;

    // Bit positions inside the {Q,N,Z,C,V} flag vector
    localparam int unsigned FLAG_Q = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FlagsWrite bit positions
    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

    // Condition codes evaluated by the condition unit
    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14
    } cond_e;

    // Checkpoint payload: Q is sticky and never checkpointed
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/ckpt_fifo.sv
// Circular buffer of flag snapshots, oldest entry presented on pop_data.
module ckpt_fifo
    import flags_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = NZCV_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;

    // Occupancy after this edge; a same-cycle pop and push cancel out
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Snapshot storage; contents are only read while the entry is valid
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/flags_reg.sv
// Architectural {Q,N,Z,C,V} register with branch checkpoint/restore.
module flags_reg #(
    parameter int unsigned CKPT_DEPTH      = 2,
    parameter int unsigned ALU_FLAGS_WIDTH = flags_pkg::ALU_FLAGS_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          wr_valid,
    input  logic                          wr_cond_ex,
    input  logic [1:0]                    wr_mask,
    input  logic                          wr_sat,
    input  logic [ALU_FLAGS_WIDTH-1:0]    alu_flags,
    input  logic                          q_clear,
    input  logic                          ckpt_take,
    input  logic                          ckpt_release,
    input  logic                          ckpt_restore,
    output logic [ALU_FLAGS_WIDTH-1:0]    flags,
    output logic [ALU_FLAGS_WIDTH-1:0]    flags_fwd,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
    output logic                          ckpt_full,
    output logic                          err
);

    import flags_pkg::FLAG_Q;
    import flags_pkg::FLAG_N;
    import flags_pkg::FLAG_Z;
    import flags_pkg::FLAG_C;
    import flags_pkg::FLAG_V;
    import flags_pkg::FW_NZ;
    import flags_pkg::FW_CV;
    import flags_pkg::NZCV_WIDTH;
    import flags_pkg::nzcv_t;

    logic  we;
    logic  take_en;
    logic  rel_en;
    logic  empty;
    logic  restore_en;
    logic  do_push;
    logic  do_pop;
    logic  err_set;
    nzcv_t head;
    nzcv_t snap;
    logic  [ALU_FLAGS_WIDTH-1:0] flags_next;
    logic  unused_alu_q;

    // The ALU's Q output is ignored; Q is driven by wr_sat only
    assign unused_alu_q = alu_flags[FLAG_Q];

    // Qualified strobes; restore overrides every other same-cycle request
    always_comb begin
        we         = wr_valid & wr_cond_ex & ~stall & ~ckpt_restore;
        take_en    = ckpt_take & ~stall & ~ckpt_restore;
        rel_en     = ckpt_release & ~stall & ~ckpt_restore;
        empty      = (ckpt_count == '0);
        restore_en = ckpt_restore & ~empty;
        do_pop     = rel_en & ~empty;
        do_push    = take_en & (~ckpt_full | rel_en);
        err_set    = (take_en & ckpt_full & ~rel_en)
                   | (rel_en & empty)
                   | (ckpt_restore & empty);
    end

    // Next flag value: restore reloads NZCV and keeps Q, otherwise masked write
    always_comb begin
        flags_next = flags;
        if (restore_en) begin
            flags_next[FLAG_N] = head.n;
            flags_next[FLAG_Z] = head.z;
            flags_next[FLAG_C] = head.c;
            flags_next[FLAG_V] = head.v;
        end else begin
            if (we && wr_mask[FW_NZ]) begin
                flags_next[FLAG_N] = alu_flags[FLAG_N];
                flags_next[FLAG_Z] = alu_flags[FLAG_Z];
            end
            if (we && wr_mask[FW_CV]) begin
                flags_next[FLAG_C] = alu_flags[FLAG_C];
                flags_next[FLAG_V] = alu_flags[FLAG_V];
            end
            if (we && wr_sat) begin
                flags_next[FLAG_Q] = 1'b1;
            end else if (q_clear && !stall) begin
                flags_next[FLAG_Q] = 1'b0;
            end
        end
    end

    assign flags_fwd = flags_next;

    // Snapshot includes any write landing in the same cycle as the take
    always_comb begin
        snap.n = flags_next[FLAG_N];
        snap.z = flags_next[FLAG_Z];
        snap.c = flags_next[FLAG_C];
        snap.v = flags_next[FLAG_V];
    end

    // Flag register and sticky protocol error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
            err   <= 1'b0;
        end else begin
            flags <= flags_next;
            if (err_set) err <= 1'b1;
        end
    end

    ckpt_fifo #(
        .DEPTH (CKPT_DEPTH),
        .WIDTH (NZCV_WIDTH)
    ) u_ckpt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .pop       (do_pop),
        .flush     (restore_en),
        .push_data (snap),
        .pop_data  (head),
        .count     (ckpt_count),
        .full      (ckpt_full)
    );

endmodule

// File: tb/tb_flags_reg.sv
// Directed bench for flags_reg with hand-computed expected values.
module tb_flags_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       wr_valid;
    logic       wr_cond_ex;
    logic [1:0] wr_mask;
    logic       wr_sat;
    logic [4:0] alu_flags;
    logic       q_clear;
    logic       ckpt_take;
    logic       ckpt_release;
    logic       ckpt_restore;
    logic [4:0] flags;
    logic [4:0] flags_fwd;
    logic [1:0] ckpt_count;
    logic       ckpt_full;
    logic       err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    flags_reg #(
        .CKPT_DEPTH      (2),
        .ALU_FLAGS_WIDTH (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .wr_valid     (wr_valid),
        .wr_cond_ex   (wr_cond_ex),
        .wr_mask      (wr_mask),
        .wr_sat       (wr_sat),
        .alu_flags    (alu_flags),
        .q_clear      (q_clear),
        .ckpt_take    (ckpt_take),
        .ckpt_release (ckpt_release),
        .ckpt_restore (ckpt_restore),
        .flags        (flags),
        .flags_fwd    (flags_fwd),
        .ckpt_count   (ckpt_count),
        .ckpt_full    (ckpt_full),
        .err          (err)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [4:0] ef, input logic [1:0] ec,
                               input logic efull, input logic eerr);
        cmp({tag, ".flags"}, 8'(flags), 8'(ef));
        cmp({tag, ".count"}, 8'(ckpt_count), 8'(ec));
        cmp({tag, ".full"},  8'(ckpt_full), 8'(efull));
        cmp({tag, ".err"},   8'(err), 8'(eerr));
    endtask

    task automatic check_flags(input string tag, input logic [4:0] ef);
        cmp(tag, 8'(flags), 8'(ef));
    endtask

    task automatic check_fwd(input string tag, input logic [4:0] ef);
        cmp(tag, 8'(flags_fwd), 8'(ef));
    endtask

    task automatic idle();
        stall        = 1'b0;
        wr_valid     = 1'b0;
        wr_cond_ex   = 1'b0;
        wr_mask      = 2'b00;
        wr_sat       = 1'b0;
        alu_flags    = 5'b0;
        q_clear      = 1'b0;
        ckpt_take    = 1'b0;
        ckpt_release = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic wr(input logic [1:0] mask, input logic [4:0] alu);
        wr_valid   = 1'b1;
        wr_cond_ex = 1'b1;
        wr_mask    = mask;
        alu_flags  = alu;
    endtask

    // One edge, then settle and return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 5'b0_0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Full NZCV write: bypass same cycle, register one cycle later
        wr(2'b11, 5'b0_1010);
        #1;
        check_fwd("wr_nzcv.fwd", 5'b0_1010);
        check_flags("wr_nzcv.pre_edge", 5'b0_0000);
        tick();
        check_state("wr_nzcv", 5'b0_1010, 2'd0, 1'b0, 1'b0);

        // Partial masks and failed condition
        wr(2'b11, 5'b0_0000);
        tick();
        check_flags("clear_all", 5'b0_0000);
        wr(2'b01, 5'b0_1111);
        tick();
        check_flags("mask_cv", 5'b0_0011);
        wr(2'b11, 5'b0_1100);
        wr_cond_ex = 1'b0;
        tick();
        check_flags("cond_fail", 5'b0_0011);

        // Sticky Q: set beats clear, clear alone, stalled clear ignored
        wr(2'b00, 5'b0_0000);
        wr_sat  = 1'b1;
        q_clear = 1'b1;
        tick();
        check_flags("q_set_wins", 5'b1_0011);
        q_clear = 1'b1;
        tick();
        check_flags("q_clear", 5'b0_0011);
        wr(2'b00, 5'b0_0000);
        wr_sat = 1'b1;
        tick();
        stall   = 1'b1;
        q_clear = 1'b1;
        wr(2'b11, 5'b0_1100);
        #1;
        check_fwd("stall_hold.fwd", 5'b1_0011);
        tick();
        check_flags("stall_hold", 5'b1_0011);

        // Take, overwrite, set Q, restore keeps Q and reloads NZCV
        q_clear = 1'b1;
        wr(2'b11, 5'b0_0100);
        tick();
        check_flags("setup_0100", 5'b0_0100);
        ckpt_take = 1'b1;
        tick();
        check_state("take1", 5'b0_0100, 2'd1, 1'b0, 1'b0);
        wr(2'b11, 5'b0_1000);
        tick();
        wr(2'b00, 5'b0_0000);
        wr_sat = 1'b1;
        tick();
        check_flags("pre_restore", 5'b1_1000);
        ckpt_restore = 1'b1;
        #1;
        check_fwd("restore.fwd", 5'b1_0100);
        tick();
        check_state("restore", 5'b1_0100, 2'd0, 1'b0, 1'b0);

        // Snapshot captures a same-cycle write
        ckpt_take = 1'b1;
        wr(2'b01, 5'b0_0001);
        #1;
        check_fwd("take_wr.fwd", 5'b1_0101);
        tick();
        wr(2'b11, 5'b0_0000);
        tick();
        ckpt_restore = 1'b1;
        tick();
        check_state("take_wr_restore", 5'b1_0101, 2'd0, 1'b0, 1'b0);

        // Fill, take+release when full, overflow, pointer wrap
        ckpt_take = 1'b1;
        wr(2'b11, 5'b0_0001);
        tick();
        ckpt_take = 1'b1;
        wr(2'b11, 5'b0_0010);
        tick();
        check_state("full", 5'b1_0010, 2'd2, 1'b1, 1'b0);
        ckpt_take    = 1'b1;
        ckpt_release = 1'b1;
        wr(2'b11, 5'b0_0011);
        tick();
        check_state("take_release_full", 5'b1_0011, 2'd2, 1'b1, 1'b0);
        ckpt_take = 1'b1;
        wr(2'b11, 5'b0_0100);
        tick();
        check_state("overflow", 5'b1_0100, 2'd2, 1'b1, 1'b1);
        ckpt_release = 1'b1;
        tick();
        check_state("release", 5'b1_0100, 2'd1, 1'b0, 1'b1);
        ckpt_restore = 1'b1;
        tick();
        check_state("restore_wrapped", 5'b1_0011, 2'd0, 1'b0, 1'b1);

        // Restore under stall wins over a same-cycle write
        ckpt_take = 1'b1;
        tick();
        wr(2'b11, 5'b0_1100);
        tick();
        check_flags("pre_stall_restore", 5'b1_1100);
        stall        = 1'b1;
        ckpt_restore = 1'b1;
        wr(2'b11, 5'b0_0000);
        #1;
        check_fwd("stall_restore.fwd", 5'b1_0011);
        tick();
        check_state("stall_restore", 5'b1_0011, 2'd0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of activity
        ckpt_take = 1'b1;
        wr(2'b11, 5'b0_1111);
        tick();
        check_state("pre_reset", 5'b1_1111, 2'd1, 1'b0, 1'b1);
        ckpt_take    = 1'b1;
        ckpt_restore = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_state("async_reset", 5'b0_0000, 2'd0, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        check_state("reset_held", 5'b0_0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Release on empty is an error
        ckpt_release = 1'b1;
        tick();
        check_state("release_empty", 5'b0_0000, 2'd0, 1'b0, 1'b1);

        // Restore on empty is an error and still drops the write
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        check_state("err_reset", 5'b0_0000, 2'd0, 1'b0, 1'b0);
        ckpt_restore = 1'b1;
        wr(2'b11, 5'b0_1111);
        tick();
        check_state("restore_empty", 5'b0_0000, 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flags_reg.md
FLAGS_REG -- requirements
Module: flags_reg

Interface
REQ-001 Parameter CKPT_DEPTH, default 2, number of flag checkpoint entries (power of two, at least 2).
REQ-002 Parameter ALU_FLAGS_WIDTH, default 5, flag vector width, ordered {Q,N,Z,C,V}, MSB first.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  pipeline hold; blocks writes, take and release, but not restore.
REQ-006 wr_valid  in  1  execute-stage instruction present.
REQ-007 wr_cond_ex  in  1  condition passed (CondEx) for that instruction.
REQ-008 wr_mask  in  2  FlagsWrite: bit1 updates N,Z; bit0 updates C,V.
REQ-009 wr_sat  in  1  instruction saturated; sets sticky Q.
REQ-010 alu_flags  in  5  {Q,N,Z,C,V} produced by the ALU; bit 4 is ignored.
REQ-011 q_clear  in  1  clear sticky Q.
REQ-012 ckpt_take  in  1  branch issued; push a snapshot.
REQ-013 ckpt_release  in  1  oldest branch resolved correct; pop without restore.
REQ-014 ckpt_restore  in  1  oldest branch mispredicted; restore its snapshot and flush all entries.
REQ-015 flags  out  5  architectural {Q,N,Z,C,V}, registered.
REQ-016 flags_fwd  out  5  combinational next-state value (bypass for the condition unit).
REQ-017 ckpt_count  out  $clog2(CKPT_DEPTH)+1  number of valid checkpoints.
REQ-018 ckpt_full  out  1  ckpt_count == CKPT_DEPTH.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 Write enable: we = wr_valid & wr_cond_ex & ~stall & ~ckpt_restore.
REQ-021 When we & wr_mask[1], N,Z take alu_flags[3:2]; when we & wr_mask[0], C,V take alu_flags[1:0]; otherwise N,Z,C,V hold.
REQ-022 Q sets when we & wr_sat; Q clears when q_clear & ~stall; set wins over a same-cycle clear.
REQ-023 flags_fwd equals the value flags will hold after the next edge; flags reflects a write one cycle later (latency 1).
REQ-024 Take (ckpt_take & ~stall & ~ckpt_restore) pushes flags_fwd, i.e. the snapshot includes a same-cycle write.
REQ-025 Release (ckpt_release & ~stall & ~ckpt_restore) pops the oldest entry; flags are unaffected.
REQ-026 Take and release in the same cycle both occur and ckpt_count is unchanged; this is legal even when full, since the pop happens before the push.
REQ-027 Restore loads N,Z,C,V from the oldest entry, keeps Q's current value (Q is sticky), sets ckpt_count to 0, and takes effect even under stall.
REQ-028 Restore has priority over a same-cycle write, take and release, which are dropped without error.
REQ-029 Take when full without release: push dropped, err set; release or restore when empty: no-op, err set.
REQ-030 Entry storage is a circular buffer with a read and a write pointer that wrap modulo CKPT_DEPTH; a wrapping pointer does not corrupt entries.
REQ-031 err clears only on reset.

Reset
REQ-032 Asserting reset asynchronously sets flags=0, ckpt_count=0, both pointers=0 and err=0; ckpt_full then reads 0.
REQ-033 Reset asserted mid-operation aborts pending takes and restores; no partial state survives.
REQ-034 Checkpoint data storage needs no reset; it is never read while its entry is invalid.

Structure
REQ-035 Package flags_pkg holds: ALU_FLAGS_WIDTH; bit indices FLAG_Q=4, FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0; the 4-bit condition-code enum (EQ..AL); and the FlagsWrite bit positions.
REQ-036 The checkpoint buffer is one sub-module, ckpt_fifo, with push, pop, flush, data, count and full ports; flags_reg contains the register, priority logic and error logic.

Verification
REQ-037 Reset, then write alu_flags=5'b0_1010 with wr_mask=2'b11 -> flags_fwd=5'b0_1010 in the same cycle, flags=5'b0_1010 the next cycle.
REQ-038 flags=0, write alu_flags=5'b0_1111 with wr_mask=2'b01 -> flags=5'b0_0011; repeat with wr_cond_ex=0 -> flags unchanged.
REQ-039 wr_sat=1 with q_clear=1 in the same cycle -> Q=1; then q_clear alone -> Q=0; then a stalled q_clear -> Q unchanged.
REQ-040 flags=5'b0_0100, take; write 5'b0_1000; set Q via wr_sat; restore -> flags=5'b1_0100, ckpt_count=0.
REQ-041 Two takes -> ckpt_full=1; take+release together -> count stays 2, err=0; a third lone take -> err=1, count 2.
REQ-042 Restore asserted with stall=1 and a same-cycle write -> restore applied, write dropped; reset pulsed mid-sequence -> all outputs 0.
